// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared types and encodings for the multicycle ARM-subset
// controller.
//   state_e          : controller FSM states
//   ALU_ADD/ALU_SUB  : ALUControl command codes
//   RES_*            : ResultSrc encodings
//   SRCB_*           : ALUSrcB encodings
//   OP_*             : Instr[27:26] major opcode classes
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // TST/TEQ/CMP/CMN share Funct[4:3]=10 and never write a register.
  function automatic logic is_compare(input logic [5:0] funct);
    return (funct[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// cond_check -- evaluates the ARM condition field against the status flags.
//   cond_i    : Instr[31:28] condition code
//   flags_i   : {N,Z,C,V}
//   cond_ex_o : 1 when the instruction should execute (Cond=1111 never does)
module cond_check (
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n_s, z_s, c_s, v_s;
  assign {n_s, z_s, c_s, v_s} = flags_i;

  // ARM EQ..AL condition table
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      4'b0000: cond_ex_o = z_s;
      4'b0001: cond_ex_o = ~z_s;
      4'b0010: cond_ex_o = c_s;
      4'b0011: cond_ex_o = ~c_s;
      4'b0100: cond_ex_o = n_s;
      4'b0101: cond_ex_o = ~n_s;
      4'b0110: cond_ex_o = v_s;
      4'b0111: cond_ex_o = ~v_s;
      4'b1000: cond_ex_o = c_s & ~z_s;
      4'b1001: cond_ex_o = ~c_s | z_s;
      4'b1010: cond_ex_o = (n_s == v_s);
      4'b1011: cond_ex_o = (n_s != v_s);
      4'b1100: cond_ex_o = ~z_s & (n_s == v_s);
      4'b1101: cond_ex_o = z_s | (n_s != v_s);
      4'b1110: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for a multicycle ARM-subset datapath.
//   clk, reset     : clock and synchronous active-high reset
//   Instr          : latched instruction (Cond, Op, Funct, Rd, L fields used)
//   ALUFlags       : {N,Z,C,V} from the ALU this cycle
//   PCWrite..RegWrite : datapath enables
//   ResultSrc, AdrSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc : datapath selects
//   ALUControl     : ALU command
//   StatusRegister : registered {N,Z,C,V}
//   branch_link    : request to write the link register (R14)
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_CMD_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALU_CMD_W-1:0] ALUControl,
  output logic [3:0]           StatusRegister,
  output logic                 branch_link
);

  state_e     state_q, state_d;
  logic [3:0] status_q;
  logic       cond_ex_q;
  logic       cond_ex_s;
  logic       wb_cond_s;

  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic       rd_pc_s;
  logic       unused_instr_s;

  assign op_s           = Instr[27:26];
  assign funct_s        = Instr[25:20];
  assign rd_pc_s        = (Instr[15:12] == 4'b1111);
  assign unused_instr_s = ^{Instr[19:16], Instr[11:0]};

  cond_check u_cond_check (
    .cond_i    (Instr[31:28]),
    .flags_i   (status_q),
    .cond_ex_o (cond_ex_s)
  );

  // In ALUWB the flags may already hold this instruction's own result, so
  // use the condition captured during execute instead of re-evaluating.
  assign wb_cond_s = (state_q == S_ALUWB) ? cond_ex_q : cond_ex_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Status flags and captured execute-stage condition
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q  <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else if ((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) begin
      cond_ex_q <= cond_ex_s;
      if (funct_s[0] && cond_ex_s) begin
        status_q <= ALUFlags;
      end
    end else begin
      cond_ex_q <= cond_ex_q;
    end
  end

  assign StatusRegister = status_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_s)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct_s[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; while reset is high the FETCH selects are shown with all
  // write enables held off.
  always_comb begin
    PCWrite     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_WD;
    ALUControl  = '0;
    branch_link = 1'b0;
    ImmSrc      = op_s;
    RegSrc      = {(op_s == OP_MEM) && !funct_s[0], (op_s == OP_BR)};
    case (reset ? S_FETCH : state_q)
      S_FETCH: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ALUControl = ALU_ADD;
      end
      S_DECODE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ALUControl = ALU_ADD;
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = funct_s[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_s;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = wb_cond_s;
        PCWrite   = wb_cond_s & rd_pc_s;
      end
      S_EXECUTER: begin
        ALUSrcB    = SRCB_WD;
        ALUControl = funct_s[4:1];
      end
      S_EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = funct_s[4:1];
      end
      S_ALUWB: begin
        RegWrite = wb_cond_s & ~is_compare(funct_s);
        PCWrite  = wb_cond_s & ~is_compare(funct_s) & rd_pc_s;
      end
      S_BRANCH: begin
        ALUSrcB     = SRCB_IMM;
        ResultSrc   = RES_ALURESULT;
        ALUControl  = ALU_ADD;
        PCWrite     = cond_ex_s;
        branch_link = cond_ex_s & Instr[24];
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      branch_link = 1'b0;
    end else begin
      // decoded values stand
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, branch_link;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]  ALUControl, StatusRegister;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.ALU_CMD_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .Instr          (Instr),
    .ALUFlags       (ALUFlags),
    .PCWrite        (PCWrite),
    .AdrSrc         (AdrSrc),
    .MemWrite       (MemWrite),
    .IRWrite        (IRWrite),
    .RegWrite       (RegWrite),
    .ResultSrc      (ResultSrc),
    .ALUSrcA        (ALUSrcA),
    .ALUSrcB        (ALUSrcB),
    .ImmSrc         (ImmSrc),
    .RegSrc         (RegSrc),
    .ALUControl     (ALUControl),
    .StatusRegister (StatusRegister),
    .branch_link    (branch_link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,branch_link}
  logic [14:0] outs;
  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, branch_link};

  function automatic logic [14:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [3:0] alu, input logic bl);
    return {pcw, adr, mw, irw, rw, rs, asa, asb, alu, bl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [14:0] F_V, D_V, MA_ADD, MEM_AD, MWB_V, AW_W, AW_N, AW_PC;
  logic [14:0] ER_ADD, EI_SUB, ER_CMP, BR_T, BR_L;

  initial begin
    F_V    = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 4'b0100, 1'b0);
    D_V    = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 4'b0100, 1'b0);
    MA_ADD = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0100, 1'b0);
    MEM_AD = pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, 1'b0);
    MWB_V  = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 4'b0000, 1'b0);
    AW_W   = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, 1'b0);
    AW_N   = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, 1'b0);
    AW_PC  = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, 1'b0);
    ER_ADD = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0);
    EI_SUB = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0010, 1'b0);
    ER_CMP = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1010, 1'b0);
    BR_T   = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 4'b0100, 1'b0);
    BR_L   = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 4'b0100, 1'b1);

    reset    = 1'b1;
    Instr    = 32'h0000_0000;
    ALUFlags = 4'b0000;
    repeat (2) @(posedge clk);
    step();
    chk("rst_outs", {17'd0, outs}, {17'd0, D_V});
    chk("rst_sr", {28'd0, StatusRegister}, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_fetch", {17'd0, outs}, {17'd0, F_V});

    // ADD R1,R2,R3 with flags on the bus that must not be taken
    Instr = 32'hE082_1003; ALUFlags = 4'b1111;
    step(); chk("add_D", {17'd0, outs}, {17'd0, D_V});
    step(); chk("add_ER", {17'd0, outs}, {17'd0, ER_ADD});
    step(); chk("add_AW", {17'd0, outs}, {17'd0, AW_W});
    step(); chk("add_F", {17'd0, outs}, {17'd0, F_V});
    chk("add_sr", {28'd0, StatusRegister}, 32'h0);

    // ADD PC,R2,R3 : write-back to R15 also writes PC
    Instr = 32'hE082_F003;
    step(); step(); step(); chk("addpc_AW", {17'd0, outs}, {17'd0, AW_PC});
    step();

    // SUBS R0,R0,#1 producing Z
    Instr = 32'hE250_0001; ALUFlags = 4'b0100;
    step(); step(); chk("subs_EI", {17'd0, outs}, {17'd0, EI_SUB});
    step(); chk("subs_AW", {17'd0, outs}, {17'd0, AW_W});
    chk("subs_sr", {28'd0, StatusRegister}, 32'h4);
    step();

    // BEQ taken
    Instr = 32'h0A00_0002; ALUFlags = 4'b0000;
    step(); chk("beq_regsrc", {30'd0, RegSrc}, 32'h1);
    chk("beq_immsrc", {30'd0, ImmSrc}, 32'h2);
    step(); chk("beq_BR", {17'd0, outs}, {17'd0, BR_T});
    step(); chk("beq_F", {17'd0, outs}, {17'd0, F_V});

    // LDR R4,[R5,#8] : five cycles
    Instr = 32'hE595_4008;
    step(); step(); chk("ldr_MA", {17'd0, outs}, {17'd0, MA_ADD});
    step(); chk("ldr_MR", {17'd0, outs}, {17'd0, MEM_AD});
    step(); chk("ldr_MWB", {17'd0, outs}, {17'd0, MWB_V});
    step(); chk("ldr_F", {17'd0, outs}, {17'd0, F_V});

    // STRNE with Z=1 : no store, four cycles
    Instr = 32'h1585_4000;
    step(); chk("strne_regsrc", {30'd0, RegSrc}, 32'h2);
    step(); chk("strne_MA", {17'd0, outs}, {17'd0, MA_ADD});
    step(); chk("strne_MW", {17'd0, outs}, {17'd0, MEM_AD});
    step(); chk("strne_F", {17'd0, outs}, {17'd0, F_V});

    // BL
    Instr = 32'hEB00_0010;
    step(); step(); chk("bl_BR", {17'd0, outs}, {17'd0, BR_L});
    step();

    // CMP R0,R1 : flags load, no register write
    Instr = 32'hE150_0001; ALUFlags = 4'b0010;
    step(); step(); chk("cmp_ER", {17'd0, outs}, {17'd0, ER_CMP});
    step(); chk("cmp_AW", {17'd0, outs}, {17'd0, AW_N});
    chk("cmp_sr", {28'd0, StatusRegister}, 32'h2);
    step();

    // SUBSEQ with Z=0 : flags hold, no write
    Instr = 32'h0250_0001; ALUFlags = 4'b1111;
    step(); step(); step(); chk("subseq_AW", {17'd0, outs}, {17'd0, AW_N});
    chk("subseq_sr", {28'd0, StatusRegister}, 32'h2);
    step();

    // SUBSNE with Z=0 setting Z : write still happens (old flags decide)
    Instr = 32'h1250_0001; ALUFlags = 4'b0100;
    step(); step(); step(); chk("subsne_AW", {17'd0, outs}, {17'd0, AW_W});
    chk("subsne_sr", {28'd0, StatusRegister}, 32'h4);
    step();

    // Op=11 : two-cycle NOP
    Instr = 32'hEC00_0000;
    step(); chk("nop_D", {17'd0, outs}, {17'd0, D_V});
    step(); chk("nop_F", {17'd0, outs}, {17'd0, F_V});

    // LDR interrupted by reset in MEMREAD
    Instr = 32'hE595_4008;
    step(); step(); step(); chk("ldr2_MR", {17'd0, outs}, {17'd0, MEM_AD});
    reset = 1'b1;
    #1; chk("rst_in_MR", {17'd0, outs}, {17'd0, D_V});
    step(); chk("rst_after_outs", {17'd0, outs}, {17'd0, D_V});
    chk("rst_after_sr", {28'd0, StatusRegister}, 32'h0);
    reset = 1'b0;
    #1; chk("rst_release_F", {17'd0, outs}, {17'd0, F_V});
    step(); chk("rst_release_D", {17'd0, outs}, {17'd0, D_V});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
